// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM state encoding,
// bit-period arithmetic and the frame-length formula used by RTL and bench alike.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS = 8;

  function automatic int calc_divisor(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Whole frame in clk cycles: start + data + optional parity + stop bits
  function automatic int frame_len(input int divisor, input int parity_en, input int stop_bits);
    return divisor * (1 + DATA_BITS + parity_en + stop_bits);
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side valid/ready/data bundle shared by all byte producers of one
// uart_tx_arbiter instance.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [8*N_REQ-1:0] req_data;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/uart_tx_arbiter_bit_timer.sv
// Frame-aligned bit-period counter: counts 0..DIVISOR-1 while enabled and
// pulses bit_done on the terminal count; clear pins it at zero between frames.
module bit_timer #(
  parameter int DIVISOR = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic bit_done
);

  localparam int            CW   = $clog2(DIVISOR);
  localparam logic [CW-1:0] TERM = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt_r;
  logic          at_term_s;

  assign at_term_s = (cnt_r == TERM);

  // Bit-period counter, wrapping at the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (en) begin
      if (at_term_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
    end
  end

  assign bit_done = en & ~clear & at_term_s;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit line between N_REQ byte
// producers; each granted byte is sent LSB-first with optional parity.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  CLK_FREQ   = 50000000,
  parameter int  BAUD_RATE  = 115200,
  parameter int  N_REQ      = 4,
  parameter int  PARITY_EN  = 0,
  parameter int  PARITY_ODD = 0,
  parameter int  STOP_BITS  = 1,
  localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_arbiter_if.slave    req_if,
  output logic                tx,
  output logic                busy,
  output logic [ID_W-1:0]     grant_id
);

  localparam int              DIVISOR   = calc_divisor(CLK_FREQ, BAUD_RATE);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]   N_REQ_W   = (ID_W + 1)'(N_REQ);
  localparam logic [2:0]      LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic            ODD_SEL   = (PARITY_ODD != 0);

  if (DIVISOR < 2) begin : g_divisor_chk
    $error("uart_tx_arbiter: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if ((N_REQ < 2) || (N_REQ > 16)) begin : g_nreq_chk
    $error("uart_tx_arbiter: N_REQ must be in 2..16");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_stop_chk
    $error("uart_tx_arbiter: STOP_BITS must be 1 or 2");
  end

  uart_state_e       state_r;
  uart_state_e       state_nxt_s;
  logic [7:0]        shreg_r;
  logic [7:0]        shreg_nxt_s;
  logic              parity_r;
  logic              parity_nxt_s;
  logic [2:0]        bit_idx_r;
  logic [2:0]        bit_idx_nxt_s;
  logic [ID_W-1:0]   grant_id_r;
  logic [ID_W-1:0]   grant_nxt_s;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [ID_W-1:0]   rr_nxt_s;
  logic              tx_r;
  logic              tx_nxt_s;
  logic              busy_r;
  logic              busy_nxt_s;

  logic              found_s;
  logic [ID_W-1:0]   winner_s;
  logic [ID_W:0]     idx_s;
  logic [7:0]        win_byte_s;
  logic [N_REQ-1:0]  ready_s;
  logic              hs_s;
  logic              timer_clear_s;
  logic              timer_en_s;
  logic              bit_done_s;

  assign timer_clear_s = (state_r == IDLE);
  assign timer_en_s    = (state_r != IDLE);

  bit_timer #(
    .DIVISOR (DIVISOR)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear_s),
    .en       (timer_en_s),
    .bit_done (bit_done_s)
  );

  // First valid requester searching upward from rr_ptr_r, wrapping at N_REQ
  always_comb begin
    found_s  = 1'b0;
    winner_s = {ID_W{1'b0}};
    idx_s    = {(ID_W + 1){1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = {1'b0, rr_ptr_r} + (ID_W + 1)'(k);
      if (idx_s >= N_REQ_W) begin
        idx_s = idx_s - N_REQ_W;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_if.req_valid[idx_s[ID_W-1:0]]) begin
        found_s  = 1'b1;
        winner_s = idx_s[ID_W-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Winner's byte and one-hot ready, offered only while idle
  always_comb begin
    win_byte_s = 8'h00;
    ready_s    = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (found_s && (winner_s == ID_W'(i))) begin
        win_byte_s = req_if.req_data[8*i +: 8];
        ready_s[i] = (state_r == IDLE);
      end else begin
        ready_s[i] = 1'b0;
      end
    end
  end

  assign hs_s           = found_s && (state_r == IDLE);
  assign req_if.req_ready = ready_s;

  // Frame FSM next state plus next values of the registered line outputs
  always_comb begin
    state_nxt_s   = state_r;
    shreg_nxt_s   = shreg_r;
    parity_nxt_s  = parity_r;
    bit_idx_nxt_s = bit_idx_r;
    grant_nxt_s   = grant_id_r;
    rr_nxt_s      = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          shreg_nxt_s   = win_byte_s;
          parity_nxt_s  = parity_bit(win_byte_s, ODD_SEL);
          grant_nxt_s   = winner_s;
          rr_nxt_s      = (winner_s == LAST_ID) ? {ID_W{1'b0}} : winner_s + ID_W'(1'b1);
          bit_idx_nxt_s = 3'd0;
          state_nxt_s   = START;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          bit_idx_nxt_s = 3'd0;
          state_nxt_s   = DATA;
        end else begin
          state_nxt_s   = START;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          shreg_nxt_s = {1'b0, shreg_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            bit_idx_nxt_s = 3'd0;
            state_nxt_s   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        if (bit_done_s) begin
          bit_idx_nxt_s = 3'd0;
          state_nxt_s   = STOP;
        end else begin
          state_nxt_s   = PARITY;
        end
      end
      STOP: begin
        // bit_idx_r counts stop bits here so two-stop frames reuse the timer
        if (bit_done_s) begin
          if (bit_idx_r == LAST_STOP) begin
            bit_idx_nxt_s = 3'd0;
            state_nxt_s   = IDLE;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    case (state_nxt_s)
      START:   tx_nxt_s = 1'b0;
      DATA:    tx_nxt_s = shreg_nxt_s[0];
      PARITY:  tx_nxt_s = parity_nxt_s;
      STOP:    tx_nxt_s = 1'b1;
      IDLE:    tx_nxt_s = 1'b1;
      default: tx_nxt_s = 1'b1;
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      shreg_r    <= 8'h00;
      parity_r   <= 1'b0;
      bit_idx_r  <= 3'd0;
      grant_id_r <= {ID_W{1'b0}};
      rr_ptr_r   <= {ID_W{1'b0}};
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      shreg_r    <= shreg_nxt_s;
      parity_r   <= parity_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      grant_id_r <= grant_nxt_s;
      rr_ptr_r   <= rr_nxt_s;
      tx_r       <= tx_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  assign tx       = tx_r;
  assign busy     = busy_r;
  assign grant_id = grant_id_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: three instances (no parity, even+2 stop,
// odd+1 stop) with a per-cycle line monitor checking frames against queued bytes.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int CLK_FREQ  = 1000000;
  localparam int BAUD_RATE = 100000;
  localparam int N_REQ     = 4;
  localparam int DIV       = 10;
  localparam int ND        = 3;

  typedef struct {
    int         dut;
    int         id;
    logic [7:0] data;
  } frame_t;

  logic clk;
  logic rst_n;
  int   cycle = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   rdy0_cnt = 0;

  logic [N_REQ-1:0]   valid_v [ND];
  logic [8*N_REQ-1:0] data_v  [ND];
  logic [N_REQ-1:0]   rdy_w   [ND];
  logic               tx_w    [ND];
  logic               busy_w  [ND];
  logic [1:0]         gid_w   [ND];

  frame_t sb_q[$];

  uart_tx_arbiter_if #(.N_REQ(N_REQ)) if0 ();
  uart_tx_arbiter_if #(.N_REQ(N_REQ)) if1 ();
  uart_tx_arbiter_if #(.N_REQ(N_REQ)) if2 ();

  assign if0.req_valid = valid_v[0];
  assign if1.req_valid = valid_v[1];
  assign if2.req_valid = valid_v[2];
  assign if0.req_data  = data_v[0];
  assign if1.req_data  = data_v[1];
  assign if2.req_data  = data_v[2];
  assign rdy_w[0]      = if0.req_ready;
  assign rdy_w[1]      = if1.req_ready;
  assign rdy_w[2]      = if2.req_ready;

  uart_tx_arbiter #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .N_REQ(N_REQ),
                    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_if(if0),
    .tx(tx_w[0]), .busy(busy_w[0]), .grant_id(gid_w[0]));

  uart_tx_arbiter #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .N_REQ(N_REQ),
                    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_if(if1),
    .tx(tx_w[1]), .busy(busy_w[1]), .grant_id(gid_w[1]));

  uart_tx_arbiter #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .N_REQ(N_REQ),
                    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_if(if2),
    .tx(tx_w[2]), .busy(busy_w[2]), .grant_id(gid_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  function automatic int pe_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int odd_of(input int d);
    return (d == 2) ? 1 : 0;
  endfunction

  function automatic int sb_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic int flen(input int d);
    return frame_len(DIV, pe_of(d), sb_of(d));
  endfunction

  // Expected line level for bit slot b of a frame
  function automatic logic exp_bit(input frame_t f, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return f.data[b-1];
    if ((b == 9) && (pe_of(f.dut) != 0)) return (^f.data) ^ (odd_of(f.dut) != 0);
    return 1'b1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic push_exp(input int d, input int id, input logic [7:0] data);
    frame_t f;
    f.dut  = d;
    f.id   = id;
    f.data = data;
    sb_q.push_back(f);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the handshake cycle
  task automatic wait_hs(input int d, input int budget, output int id, output int cyc);
    id  = -1;
    cyc = -1;
    for (int k = 0; k < budget && id < 0; k++) begin
      @(negedge clk);
      if ((valid_v[d] & rdy_w[d]) != '0) begin
        cyc = cycle;
        for (int i = 0; i < N_REQ; i++) begin
          if (valid_v[d][i] && rdy_w[d][i]) id = i;
        end
      end
    end
    check_eq("hs_seen", (id >= 0), 1'b1);
  endtask

  // Called right after wait_hs: releases the requester, counts busy cycles, samples mid-bit levels
  task automatic measure(input int d, input int budget, output int blen, output logic [15:0] bits);
    blen = 0;
    bits = '0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) valid_v[d] = '0;
      if (((k % DIV) == DIV / 2) && ((k / DIV) < 16)) bits[k / DIV] = tx_w[d];
      if (busy_w[d]) blen++;
      else break;
    end
  endtask

  // Line monitor: pops the expected frame at each start bit and checks every cycle
  frame_t mon_f   [ND];
  bit     mon_act [ND];
  bit     mon_gap [ND];
  bit     mon_bad [ND];
  int     mon_cnt [ND];

  initial begin
    for (int d = 0; d < ND; d++) begin
      mon_act[d] = 1'b0;
      mon_gap[d] = 1'b0;
      mon_bad[d] = 1'b0;
      mon_cnt[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (!rst_n) begin
          mon_act[d] = 1'b0;
          mon_gap[d] = 1'b0;
        end else if (mon_gap[d]) begin
          check_eq("gap_tx", tx_w[d], 1'b1);
          check_eq("gap_busy", busy_w[d], 1'b0);
          mon_gap[d] = 1'b0;
        end else begin
          if (!mon_act[d] && (tx_w[d] == 1'b0)) begin
            check_eq("sb_pending", (sb_q.size() > 0), 1'b1);
            mon_act[d] = 1'b1;
            mon_cnt[d] = 0;
            mon_bad[d] = (sb_q.size() == 0);
            if (!mon_bad[d]) begin
              mon_f[d] = sb_q.pop_front();
              check_eq("frame_dut", mon_f[d].dut, d);
              check_eq("grant_id", gid_w[d], mon_f[d].id);
            end
          end
          if (mon_act[d]) begin
            if (!mon_bad[d]) begin
              check_eq("tx_bit", tx_w[d], exp_bit(mon_f[d], mon_cnt[d] / DIV));
              check_eq("busy_frame", busy_w[d], 1'b1);
            end
            mon_cnt[d]++;
            if (mon_cnt[d] == flen(d)) begin
              mon_act[d] = 1'b0;
              mon_gap[d] = 1'b1;
            end
          end
        end
        if (rst_n && (rdy_w[d] != '0)) begin
          check_eq("rdy_onehot", $onehot(rdy_w[d]), 1'b1);
          check_eq("rdy_valid", rdy_w[d] & ~valid_v[d], 4'h0);
          check_eq("rdy_idle", busy_w[d], 1'b0);
        end
      end
      if (rst_n && rdy_w[0][0]) rdy0_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          id;
    int          t;
    int          tp;
    int          blen;
    logic [15:0] bits;

    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      valid_v[d] = '0;
      data_v[d]  = '0;
    end
    step(2);
    for (int d = 0; d < ND; d++) begin
      check_eq("rst_tx", tx_w[d], 1'b1);
      check_eq("rst_busy", busy_w[d], 1'b0);
      check_eq("rst_ready", rdy_w[d], 4'h0);
      check_eq("rst_grant", gid_w[d], 2'd0);
    end
    rst_n = 1'b1;
    step(3);

    // Single byte from requester 2
    data_v[0][23:16] = 8'hA5;
    valid_v[0]       = 4'b0100;
    push_exp(0, 2, 8'hA5);
    wait_hs(0, 50, id, t);
    check_eq("single_id", id, 2);
    measure(0, 200, blen, bits);
    check_eq("single_busy_len", blen, 100);
    check_eq("single_bits", bits[9:0], 10'b1101001010);
    step(5);
    check_eq("single_sb_empty", sb_q.size(), 0);

    // Round-robin with all four continuously valid from reset
    rst_n = 1'b0;
    step(1);
    data_v[0]  = $urandom();
    valid_v[0] = 4'hF;
    for (int k = 0; k < 5; k++) push_exp(0, k % 4, data_v[0][8*(k % 4) +: 8]);
    step(1);
    rst_n = 1'b1;
    tp = 0;
    for (int k = 0; k < 5; k++) begin
      wait_hs(0, 300, id, t);
      check_eq("rr_id", id, k % 4);
      if (k > 0) check_eq("rr_spacing", t - tp, 101);
      tp = t;
    end
    step(1);
    valid_v[0] = '0;
    step(110);
    check_eq("rr_sb_empty", sb_q.size(), 0);

    // Mid-frame arrival plus a withdrawn request (rr_ptr is 1 here)
    data_v[0][23:16] = 8'h3C;
    valid_v[0]       = 4'b0100;
    push_exp(0, 2, 8'h3C);
    wait_hs(0, 50, id, tp);
    check_eq("mid_first_id", id, 2);
    step(1);
    valid_v[0] = '0;
    rdy0_cnt   = 0;
    step(30);
    data_v[0][7:0]  = 8'h11;
    data_v[0][15:8] = 8'h96;
    valid_v[0]      = 4'b0011;
    push_exp(0, 1, 8'h96);
    step(20);
    valid_v[0][0] = 1'b0;
    wait_hs(0, 200, id, t);
    check_eq("withdraw_id", id, 1);
    check_eq("mid_hs_cycle", t - tp, 101);
    step(1);
    valid_v[0] = '0;
    step(110);
    check_eq("withdraw_no_rdy0", rdy0_cnt, 0);
    check_eq("mid_sb_empty", sb_q.size(), 0);

    // Even parity, two stop bits
    data_v[1][7:0] = 8'h07;
    valid_v[1]     = 4'b0001;
    push_exp(1, 0, 8'h07);
    wait_hs(1, 50, id, t);
    check_eq("par_even_id", id, 0);
    measure(1, 300, blen, bits);
    check_eq("par_even_busy_len", blen, 120);
    check_eq("par_even_bit", bits[9], 1'b1);
    check_eq("par_even_frame", bits[11:0], 12'b111000001110);
    step(5);

    // Odd parity, one stop bit
    data_v[2][7:0] = 8'h07;
    valid_v[2]     = 4'b0001;
    push_exp(2, 0, 8'h07);
    wait_hs(2, 50, id, t);
    check_eq("par_odd_id", id, 0);
    measure(2, 300, blen, bits);
    check_eq("par_odd_busy_len", blen, 110);
    check_eq("par_odd_bit", bits[9], 1'b0);
    check_eq("par_odd_frame", bits[10:0], 11'b10000001110);
    step(5);
    check_eq("par_sb_empty", sb_q.size(), 0);

    // Reset 35 cycles into a frame, then a clean frame from requester 3
    data_v[0][23:16] = 8'h5A;
    valid_v[0]       = 4'b0100;
    push_exp(0, 2, 8'h5A);
    wait_hs(0, 50, id, t);
    check_eq("rstmid_id", id, 2);
    step(1);
    valid_v[0] = '0;
    step(34);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_tx", tx_w[0], 1'b1);
    check_eq("rstmid_busy", busy_w[0], 1'b0);
    check_eq("rstmid_grant", gid_w[0], 2'd0);
    data_v[0][31:24] = 8'hC3;
    valid_v[0]       = 4'b1000;
    push_exp(0, 3, 8'hC3);
    step(2);
    rst_n = 1'b1;
    wait_hs(0, 50, id, t);
    check_eq("rstmid_after_id", id, 3);
    measure(0, 200, blen, bits);
    check_eq("rstmid_busy_len", blen, 100);
    check_eq("rstmid_bits", bits[9:0], 10'b1110000110);
    step(5);
    check_eq("final_sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
